sh_mem_banked: RTL and testbench
================================

SH_MEM_BANKED -- requirements
Module: sh_mem_banked

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of core ports (1..16).
REQ-002 Parameter REG_SIZE, default 8, data word width in bits.
REQ-003 Parameter ADDR_SIZE, default 8, word address width; total depth is 2^ADDR_SIZE.
REQ-004 Parameter NUM_BANKS, default 2, power of two, at most 2^ADDR_SIZE; bank = addr[log2(NUM_BANKS)-1:0].
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enable  in  NUM_PORTS*2  per-port opcode, port i at [2i+1:2i]: 00 idle, 01 read, 10 write, 11 reserved (treated as idle).
REQ-008 addr  in  NUM_PORTS*ADDR_SIZE  per-port word address, port i at [(i+1)*ADDR_SIZE-1 : i*ADDR_SIZE].
REQ-009 wr_data  in  NUM_PORTS*REG_SIZE  per-port write data, same slicing as addr.
REQ-010 rd_data  out  NUM_PORTS*REG_SIZE  per-port read data, same slicing.
REQ-011 ready  out  NUM_PORTS  per-port one-cycle completion pulse.

Function
REQ-012 Each bank SHALL have an independent round-robin arbiter; per cycle each bank grants at most one port whose request targets it.
REQ-013 Priority SHALL start at (last granted port + 1) mod NUM_PORTS; the pointer updates only on a grant.
REQ-014 Granted in cycle t: write commits to the bank array at the edge ending t; ready[i] SHALL be 1 throughout cycle t+1.
REQ-015 Granted read: rd_data slice i SHALL hold the word in cycle t+1 and retain it until that port's next read completes.
REQ-016 A port with ready high SHALL NOT be granted that cycle, giving the requester one cycle to drop or change enable; peak rate is one access per port per 2 cycles.
REQ-017 A requester SHALL hold enable/addr/wr_data stable until ready; ungranted requests stall without loss.
REQ-018 Accesses to different banks in the same cycle SHALL all be granted (up to NUM_BANKS per cycle).
REQ-019 A read granted the cycle after a write to the same address SHALL return the written data.
REQ-020 Opcode 11 and idle SHALL never be granted and SHALL NOT move the pointer.
REQ-021 Worst-case wait for any holding requester SHALL be NUM_PORTS-1 grants on its bank.

Reset
REQ-022 While reset is high: ready = 0, rd_data = 0, all bank pointers = NUM_PORTS-1 (port 0 wins first), no grant occurs and no write commits.
REQ-023 Reset asserted in the cycle after a grant SHALL suppress that ready pulse; the write committed earlier remains.
REQ-024 Memory array contents SHALL NOT be cleared by reset.

Structure
REQ-025 Opcode constants (IDLE, READ, WRITE), ENABLE_SIZE = 2, and default widths SHALL live in the shared defines package used by Core and Task_Scheduler.
REQ-026 One sub-module rr_arbiter (parameter NUM_PORTS; request vector in, one-hot grant out, registered pointer) SHALL be instantiated once per bank.
REQ-027 The block SHALL be drop-in for the GPU top's sh_mem bus slicing when NUM_BANKS = 1.

Verification
REQ-028 Single port: write 0x5A to addr 0x10, then read 0x10 -> ready at t+1 each time, rd_data = 0x5A.
REQ-029 All 4 ports read bank 0 in the same cycle from reset -> grants in order 0,1,2,3 on consecutive cycles, one ready per cycle.
REQ-030 Port 0 reads 0x02 (bank 0) and port 1 reads 0x03 (bank 1) in the same cycle -> both ready at t+1.
REQ-031 Port 2 continuously re-requests bank 0 while port 3 requests bank 0 -> port 3 granted within 2 cycles; port 2 never granted in its ready cycle.
REQ-032 Reset asserted the cycle after port 1's write grant to 0x20=0x33 -> no ready pulse; a later read of 0x20 returns 0x33.
REQ-033 Opcode 11 on all ports for 10 cycles -> no ready pulses, pointers unchanged, memory unchanged.

Source files
------------

// File: rtl/sh_mem_banked_pkg.sv
// sh_mem_banked_pkg: shared opcodes, enable width and default widths for the shared memory bus
package sh_mem_banked_pkg;
  localparam int ENABLE_SIZE = 2;
  localparam logic [ENABLE_SIZE-1:0] IDLE  = 2'b00;
  localparam logic [ENABLE_SIZE-1:0] READ  = 2'b01;
  localparam logic [ENABLE_SIZE-1:0] WRITE = 2'b10;
  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_REG_SIZE  = 8;
  localparam int DEF_ADDR_SIZE = 8;
  localparam int DEF_NUM_BANKS = 2;
  function automatic logic is_access(input logic [ENABLE_SIZE-1:0] op);
    return op == READ || op == WRITE;
  endfunction
endpackage

// File: rtl/sh_mem_banked_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; pointer holds the last granted port and moves only on a grant
module rr_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant
);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  logic [PW-1:0] ptr_q, ptr_d, idx;
  logic found;
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = PW'((int'(ptr_q) + k) % NUM_PORTS);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_d      = idx;
      end
    end
  end
  always_ff @(posedge clk) ptr_q <= reset ? PW'(NUM_PORTS - 1) : ptr_d;
endmodule

// File: rtl/sh_mem_banked.sv
// sh_mem_banked: multi-port shared memory split into address-interleaved banks, one round-robin arbiter per bank
module sh_mem_banked
  import sh_mem_banked_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int REG_SIZE  = DEF_REG_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int NUM_BANKS = DEF_NUM_BANKS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS*ENABLE_SIZE-1:0] enable,
  input  logic [NUM_PORTS*ADDR_SIZE-1:0]   addr,
  input  logic [NUM_PORTS*REG_SIZE-1:0]    wr_data,
  output logic [NUM_PORTS*REG_SIZE-1:0]    rd_data,
  output logic [NUM_PORTS-1:0]             ready
);
  localparam int BB    = $clog2(NUM_BANKS);
  localparam int IW    = ADDR_SIZE > BB ? ADDR_SIZE - BB : 1;
  localparam int DEPTH = (2 ** ADDR_SIZE) / NUM_BANKS;
  logic [NUM_PORTS-1:0]          req [NUM_BANKS];
  logic [NUM_PORTS-1:0]          gnt [NUM_BANKS];
  logic [REG_SIZE-1:0]           bank_rd [NUM_BANKS];
  logic [NUM_PORTS-1:0]          ready_q, ready_d;
  logic [NUM_PORTS*REG_SIZE-1:0] rd_data_q, rd_data_d;
  // A port showing ready is masked so the requester gets a cycle to drop or change its opcode
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      req[b] = '0;
      for (int i = 0; i < NUM_PORTS; i++)
        req[b][i] = !reset && !ready_q[i] && is_access(enable[i*ENABLE_SIZE +: ENABLE_SIZE])
                    && (int'(addr[i*ADDR_SIZE +: ADDR_SIZE]) % NUM_BANKS == b);
    end
  end
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [REG_SIZE-1:0] mem [DEPTH];
    logic [IW-1:0]       idx;
    logic [REG_SIZE-1:0] wd;
    logic                wr;
    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req[b]),
      .grant (gnt[b])
    );
    always_comb begin
      idx = '0;
      wd  = '0;
      wr  = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++)
        if (gnt[b][i]) begin
          idx = IW'(addr[i*ADDR_SIZE +: ADDR_SIZE] >> BB);
          wd  = wr_data[i*REG_SIZE +: REG_SIZE];
          wr  = enable[i*ENABLE_SIZE +: ENABLE_SIZE] == WRITE;
        end
    end
    assign bank_rd[b] = mem[idx];
    always_ff @(posedge clk) if (wr) mem[idx] <= wd;
  end
  always_comb begin
    ready_d   = '0;
    rd_data_d = rd_data_q;
    for (int b = 0; b < NUM_BANKS; b++)
      for (int i = 0; i < NUM_PORTS; i++)
        if (gnt[b][i]) begin
          ready_d[i] = 1'b1;
          if (enable[i*ENABLE_SIZE +: ENABLE_SIZE] == READ) rd_data_d[i*REG_SIZE +: REG_SIZE] = bank_rd[b];
        end
  end
  always_ff @(posedge clk) begin
    ready_q   <= reset ? '0 : ready_d;
    rd_data_q <= reset ? '0 : rd_data_d;
  end
  // Outputs are forced low for the whole reset cycle, which also swallows a pulse already in flight
  assign ready   = reset ? '0 : ready_q;
  assign rd_data = reset ? '0 : rd_data_q;
endmodule

// File: tb/tb_sh_mem_banked.sv
// tb_sh_mem_banked: directed scenarios plus randomized traffic against a transaction-level memory model
module tb_sh_mem_banked;
  localparam logic [1:0] OP_IDLE = 2'b00, OP_RD = 2'b01, OP_WR = 2'b10, OP_RSV = 2'b11;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  enable = '0;
  logic [31:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic [3:0]  ready;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  mem_m [256];

  always #5 clk = ~clk;

  sh_mem_banked dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .ready   (ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    enable[2*p +: 2]  = op;
    addr[8*p +: 8]    = a;
    wr_data[8*p +: 8] = d;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 8'h55;
    step();
    step();
    #1;
    checks++;
    if (ready !== 4'b0) $display("FAIL reset_ready: got %b expected 0000", ready);
    checks++;
    if (rd_data !== 32'h0) $display("FAIL reset_rd_data: got %h expected 00000000", rd_data);
    enable = 8'hAA;
    step();
    #1;
    checks++;
    if (ready !== 4'b0) $display("FAIL reset_ready_wr: got %b expected 0000", ready);
    if (ready !== 4'b0 || rd_data !== 32'h0) errors++;
    enable = '0;
    reset  = 1'b0;
  endtask

  task automatic preload();
    for (int a = 0; a < 256; a++) begin
      drive(0, OP_WR, 8'(a), 8'(a) ^ 8'hA5);
      mem_m[a] = 8'(a) ^ 8'hA5;
      step();
      drive(0, OP_IDLE, 8'h0, 8'h0);
      step();
    end
  endtask

  task automatic test_single_port();
    do_reset();
    drive(0, OP_WR, 8'h10, 8'h5A);
    step();
    #1;
    checks++;
    if (ready !== 4'b0001) begin errors++; $display("FAIL sp_write_ready: got %b expected 0001", ready); end
    drive(0, OP_RD, 8'h10, 8'h00);
    step();
    #1;
    checks++;
    if (ready !== 4'b0000) begin errors++; $display("FAIL sp_ready_gap: got %b expected 0000", ready); end
    step();
    #1;
    checks++;
    if (ready !== 4'b0001) begin errors++; $display("FAIL sp_read_ready: got %b expected 0001", ready); end
    checks++;
    if (rd_data[7:0] !== 8'h5A) begin errors++; $display("FAIL sp_read_data: got %h expected 5a", rd_data[7:0]); end
    mem_m[8'h10] = 8'h5A;
    enable = '0;
  endtask

  task automatic test_all_ports_bank0();
    do_reset();
    for (int p = 0; p < 4; p++) drive(p, OP_RD, 8'(2*p), 8'h00);
    for (int c = 0; c < 4; c++) begin
      step();
      #1;
      checks++;
      if (ready !== 4'(1 << c)) begin errors++; $display("FAIL rr_order c%0d: got %b expected %b", c, ready, 4'(1 << c)); end
      checks++;
      if (rd_data[8*c +: 8] !== mem_m[2*c]) begin errors++; $display("FAIL rr_data p%0d: got %h expected %h", c, rd_data[8*c +: 8], mem_m[2*c]); end
      drive(c, OP_IDLE, 8'h0, 8'h0);
    end
    step();
    #1;
    checks++;
    if (ready !== 4'b0) begin errors++; $display("FAIL rr_drain: got %b expected 0000", ready); end
  endtask

  task automatic test_two_banks();
    do_reset();
    drive(0, OP_RD, 8'h02, 8'h00);
    drive(1, OP_RD, 8'h03, 8'h00);
    step();
    #1;
    checks++;
    if (ready !== 4'b0011) begin errors++; $display("FAIL banks_ready: got %b expected 0011", ready); end
    checks++;
    if (rd_data[15:0] !== {mem_m[3], mem_m[2]}) begin errors++; $display("FAIL banks_data: got %h expected %h", rd_data[15:0], {mem_m[3], mem_m[2]}); end
    enable = '0;
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    do_reset();
    drive(2, OP_RD, 8'h04, 8'h00);
    drive(3, OP_RD, 8'h06, 8'h00);
    for (int c = 1; c <= 8; c++) begin
      step();
      #1;
      exp = (c % 2 == 1) ? 4'b0100 : 4'b1000;
      checks++;
      if (ready !== exp) begin errors++; $display("FAIL fair c%0d: got %b expected %b", c, ready, exp); end
    end
    enable = '0;
    step();
  endtask

  task automatic test_reset_after_write();
    do_reset();
    drive(1, OP_WR, 8'h20, 8'h33);
    step();
    reset  = 1'b1;
    enable = '0;
    #1;
    checks++;
    if (ready !== 4'b0) begin errors++; $display("FAIL rst_suppress: got %b expected 0000", ready); end
    step();
    reset = 1'b0;
    drive(1, OP_RD, 8'h20, 8'h00);
    step();
    #1;
    checks++;
    if (ready !== 4'b0010) begin errors++; $display("FAIL rst_read_ready: got %b expected 0010", ready); end
    checks++;
    if (rd_data[15:8] !== 8'h33) begin errors++; $display("FAIL rst_read_data: got %h expected 33", rd_data[15:8]); end
    mem_m[8'h20] = 8'h33;
    enable = '0;
  endtask

  task automatic test_reserved();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      for (int p = 0; p < 4; p++) drive(p, OP_RSV, 8'h40 + 8'(2*p), 8'($urandom));
      step();
      #1;
      checks++;
      if (ready !== 4'b0) begin errors++; $display("FAIL rsv_ready c%0d: got %b expected 0000", c, ready); end
    end
    for (int p = 0; p < 4; p++) drive(p, OP_RD, 8'h40 + 8'(2*p), 8'h00);
    for (int c = 0; c < 4; c++) begin
      step();
      #1;
      checks++;
      if (ready !== 4'(1 << c)) begin errors++; $display("FAIL rsv_order c%0d: got %b expected %b", c, ready, 4'(1 << c)); end
      checks++;
      if (rd_data[8*c +: 8] !== mem_m[8'h40 + 2*c]) begin errors++; $display("FAIL rsv_mem p%0d: got %h expected %h", c, rd_data[8*c +: 8], mem_m[8'h40 + 2*c]); end
      drive(c, OP_IDLE, 8'h0, 8'h0);
    end
  endtask

  task automatic test_random();
    int         last_m [2];
    logic [3:0] rdy_m, nxt;
    logic [7:0] rd_m [4];
    logic [1:0] op_t [4];
    logic [7:0] a_t [4], d_t [4];
    int         r, p;
    logic       done;
    do_reset();
    last_m = '{3, 3};
    rdy_m  = '0;
    for (int i = 0; i < 4; i++) begin rd_m[i] = '0; op_t[i] = OP_IDLE; a_t[i] = '0; d_t[i] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (rdy_m[i] || !(op_t[i] == OP_RD || op_t[i] == OP_WR)) begin
          r       = $urandom_range(0, 9);
          op_t[i] = r < 4 ? OP_RD : r < 8 ? OP_WR : r == 8 ? OP_IDLE : OP_RSV;
          a_t[i]  = 8'h40 + 8'($urandom_range(0, 7));
          d_t[i]  = 8'($urandom);
        end
        drive(i, op_t[i], a_t[i], d_t[i]);
      end
      #1;
      checks++;
      if (ready !== rdy_m) begin errors++; $display("FAIL rand_ready cyc%0d: got %b expected %b", cyc, ready, rdy_m); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rd_data[8*i +: 8] !== rd_m[i]) begin errors++; $display("FAIL rand_data cyc%0d p%0d: got %h expected %h", cyc, i, rd_data[8*i +: 8], rd_m[i]); end
      end
      nxt = '0;
      for (int b = 0; b < 2; b++) begin
        done = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          p = (last_m[b] + k) % 4;
          if (!done && !rdy_m[p] && (op_t[p] == OP_RD || op_t[p] == OP_WR) && int'(a_t[p]) % 2 == b) begin
            done      = 1'b1;
            last_m[b] = p;
            nxt[p]    = 1'b1;
            if (op_t[p] == OP_RD) rd_m[p] = mem_m[a_t[p]];
            else mem_m[a_t[p]] = d_t[p];
          end
        end
      end
      rdy_m = nxt;
      step();
    end
    enable = '0;
  endtask

  initial begin
    test_reset();
    preload();
    test_single_port();
    test_all_ports_bank0();
    test_two_banks();
    test_fairness();
    test_reset_after_write();
    test_reserved();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
